delay_var: RTL and testbench

Multi-channel delay line whose delay is selectable at run time, with a clock-enable strobe, for delaying the sample streams that the fixed-length `delay` register slice cannot handle. Examples are per-channel alignment of DAC/ADC paths and latency matching across filters whose group delay depends on the current mode. It sits in the sample datapath between converter interfaces and DSP blocks, and advances only on sample strobes. Buffered history is kept in a small RAM-style ring buffer rather than a shift-register chain.

---
 rtl/delay_pkg.sv | 21 ++
 rtl/delay_ram.sv | 26 ++
 rtl/delay_var.sv | 117 +++++++++++
 tb/tb_delay_var.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/delay_pkg.sv
// Shared helpers for the run-time selectable delay line: delay clamping
// and the delay-select type for the default 16-deep configuration.
package delay_pkg;

   localparam int unsigned DEF_MAX_CYCLES = 16;
   localparam int unsigned DEF_DELAY_W    = $clog2(DEF_MAX_CYCLES + 1);

   typedef logic [DEF_DELAY_W-1:0] delay_t;

   // Requested delay forced into 1..max_cycles; 0 acts as 1.
   function automatic int unsigned clamp_delay(input int unsigned req,
                                               input int unsigned max_cycles);
      if (req < 1)
         return 1;
      else if (req > max_cycles)
         return max_cycles;
      else
         return req;
   endfunction

endpackage

// File: rtl/delay_ram.sv
// History buffer for delay_var: one synchronous write port, one
// combinational read port. Contents are deliberately never reset.
module delay_ram #(
   parameter int width = 48,
   parameter int depth = 16,
   parameter int aw    = 4
) (
   input  logic             clk,
   input  logic             we,
   input  logic [aw-1:0]    waddr,
   input  logic [width-1:0] wdata,
   input  logic [aw-1:0]    raddr,
   output logic [width-1:0] rdata
);

   logic [width-1:0] mem [depth];

   // Store the incoming sample at the write pointer.
   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/delay_var.sv
// Multi-channel delay line with a run-time delay select and sample strobe.
// History lives in a ring buffer; a saturating fill counter keeps unwritten
// (unreset) buffer entries from ever reaching the output.
module delay_var
   import delay_pkg::*;
#(
   parameter int              num_bits        = 24,
   parameter int              num_channels    = 2,
   parameter int              max_cycles      = 16,
   parameter logic [num_bits-1:0] initial_val = '0,
   parameter bit              flush_on_change = 1'b1,
   localparam int             delay_w         = $clog2(max_cycles + 1)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             en,
   input  logic [delay_w-1:0]               delay_cycles,
   input  logic [num_channels*num_bits-1:0] in,
   output logic [num_channels*num_bits-1:0] out,
   output logic                             out_valid
);

   localparam int dat_w = num_channels * num_bits;
   localparam int aw    = (max_cycles > 1) ? $clog2(max_cycles) : 1;
   localparam int fw    = $clog2(max_cycles + 1);

   localparam logic [dat_w-1:0] init_vec = {num_channels{initial_val}};

   logic [aw-1:0]      wp;
   logic [aw-1:0]      wp_next;
   logic [aw-1:0]      rd_addr;
   logic [fw-1:0]      fill;
   logic [fw-1:0]      fill_next;
   logic [delay_w-1:0] d_q;
   logic [delay_w-1:0] d_eff;
   logic [dat_w-1:0]   ram_rdata;
   logic [dat_w-1:0]   rd_val;
   logic               fill_ok;
   logic               d_change;
   logic               ram_we;

   assign d_eff = delay_w'(clamp_delay(32'(delay_cycles), max_cycles));

   // Read address is wp-(d-1) modulo max_cycles, computed wide so a
   // non-power-of-two depth wraps correctly.
   always_comb begin
      logic [31:0] rd_sum;
      rd_sum = 32'(wp) + 32'(max_cycles) + 32'd1 - 32'(d_eff);
      if (rd_sum >= 32'(max_cycles))
         rd_sum = rd_sum - 32'(max_cycles);
      rd_addr = aw'(rd_sum);
   end

   // Write pointer advance with an explicit wrap at max_cycles-1.
   always_comb begin
      if (32'(wp) == 32'(max_cycles - 1))
         wp_next = '0;
      else
         wp_next = wp + 1'b1;
   end

   // Saturating fill count and the history-valid test (fill >= d-1).
   always_comb begin
      if (32'(fill) >= 32'(max_cycles))
         fill_next = fill;
      else
         fill_next = fill + 1'b1;
      fill_ok  = (32'(fill) + 32'd1) >= 32'(d_eff);
      d_change = (d_eff != d_q);
      rd_val   = (d_eff == delay_w'(1)) ? in : ram_rdata;
   end

   assign ram_we = en & ~reset;

   delay_ram #(
      .width (dat_w),
      .depth (max_cycles),
      .aw    (aw)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (wp),
      .wdata (in),
      .raddr (rd_addr),
      .rdata (ram_rdata)
   );

   // Pointer, fill, latched delay and output registers; all advance on strobes only.
   always_ff @(posedge clk) begin
      if (reset) begin
         wp        <= '0;
         fill      <= '0;
         d_q       <= delay_w'(max_cycles);
         out       <= init_vec;
         out_valid <= 1'b0;
      end else if (en) begin
         wp <= wp_next;
         if (d_change)
            d_q <= d_eff;
         if (d_change && flush_on_change) begin
            fill      <= fw'(1);
            out       <= init_vec;
            out_valid <= 1'b0;
         end else begin
            fill <= fill_next;
            if (fill_ok) begin
               out       <= rd_val;
               out_valid <= 1'b1;
            end else begin
               out       <= init_vec;
               out_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_delay_var.sv
// Scoreboard bench for delay_var: two instances (flush and no-flush on delay
// change) share stimulus; a reference model built on a sample-history queue
// predicts each cycle's outputs, and a monitor compares them.
module tb_delay_var;
   import delay_pkg::*;

   localparam int NB   = 8;
   localparam int NC   = 2;
   localparam int MAXC = 16;
   localparam logic [NB-1:0] INIT = 8'hA5;
   localparam logic [NC*NB-1:0] INIT_VEC = {NC{INIT}};

   logic           clk = 1'b0;
   logic           reset;
   logic           en;
   delay_t         delay_cycles;
   logic [NC*NB-1:0] in;
   logic [NC*NB-1:0] out_f, out_n;
   logic           v_f, v_n;

   always #5 clk = ~clk;

   delay_var #(
      .num_bits(NB), .num_channels(NC), .max_cycles(MAXC),
      .initial_val(INIT), .flush_on_change(1'b1)
   ) dut_flush (
      .clk(clk), .reset(reset), .en(en), .delay_cycles(delay_cycles),
      .in(in), .out(out_f), .out_valid(v_f)
   );

   delay_var #(
      .num_bits(NB), .num_channels(NC), .max_cycles(MAXC),
      .initial_val(INIT), .flush_on_change(1'b0)
   ) dut_noflush (
      .clk(clk), .reset(reset), .en(en), .delay_cycles(delay_cycles),
      .in(in), .out(out_n), .out_valid(v_n)
   );

   typedef struct {
      logic [NC*NB-1:0] of;
      logic             vf;
      logic [NC*NB-1:0] on;
      logic             vn;
   } exp_t;

   exp_t sb[$];

   // Reference model: all samples since reset, and per-instance count of
   // strobes since the history became usable.
   logic [NC*NB-1:0] hist[$];
   int               age_f, age_n, dq;
   logic [NC*NB-1:0] mo_f, mo_n;
   logic             mv_f, mv_n;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic step(input bit r, input bit e, input int dc,
                       input logic [NB-1:0] a, input logic [NB-1:0] b);
      int   d;
      exp_t x;
      @(negedge clk);
      reset        = r;
      en           = e;
      delay_cycles = delay_t'(dc);
      in           = {b, a};
      if (r) begin
         hist.delete();
         age_f = 0; age_n = 0; dq = MAXC;
         mo_f = INIT_VEC; mv_f = 1'b0;
         mo_n = INIT_VEC; mv_n = 1'b0;
      end else if (e) begin
         d = (dc < 1) ? 1 : ((dc > MAXC) ? MAXC : dc);
         hist.push_back({b, a});
         if (hist.size() > 40) void'(hist.pop_front());
         if (d != dq) begin
            mo_f = INIT_VEC; mv_f = 1'b0; age_f = 1;
         end else begin
            if (age_f >= d - 1) begin
               mo_f = hist[hist.size() - d]; mv_f = 1'b1;
            end else begin
               mo_f = INIT_VEC; mv_f = 1'b0;
            end
            age_f++;
         end
         if (age_n >= d - 1) begin
            mo_n = hist[hist.size() - d]; mv_n = 1'b1;
         end else begin
            mo_n = INIT_VEC; mv_n = 1'b0;
         end
         age_n++;
         dq = d;
      end
      x.of = mo_f; x.vf = mv_f; x.on = mo_n; x.vn = mv_n;
      sb.push_back(x);
   endtask

   // Monitor: after every edge that had stimulus queued, compare both instances.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            x = sb.pop_front();
            n_tests++;
            if (out_f !== x.of) begin
               n_fail++;
               $display("FAIL out_flush: got %h expected %h at %0t", out_f, x.of, $time);
            end
            n_tests++;
            if (v_f !== x.vf) begin
               n_fail++;
               $display("FAIL valid_flush: got %b expected %b at %0t", v_f, x.vf, $time);
            end
            n_tests++;
            if (out_n !== x.on) begin
               n_fail++;
               $display("FAIL out_noflush: got %h expected %h at %0t", out_n, x.on, $time);
            end
            n_tests++;
            if (v_n !== x.vn) begin
               n_fail++;
               $display("FAIL valid_noflush: got %b expected %b at %0t", v_n, x.vn, $time);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cur_dc;
      bit r, e;
      reset = 1'b1; en = 1'b0; delay_cycles = '0; in = '0;
      age_f = 0; age_n = 0; dq = MAXC;
      mo_f = INIT_VEC; mv_f = 1'b0; mo_n = INIT_VEC; mv_n = 1'b0;

      // reset, then hold with en low while inputs toggle
      step(1, 0, 4, 8'h00, 8'h00);
      step(1, 1, 4, 8'h11, 8'h22);
      for (int i = 0; i < 5; i++) step(0, 0, 4, 8'(i * 37), 8'(i * 91));

      // fixed delay 4, ramp on ch0, ramp+100 on ch1
      for (int i = 1; i <= 12; i++) step(0, 1, 4, 8'(i), 8'(i + 100));

      // strobe every third cycle, d=2
      for (int i = 0; i < 15; i++) step(0, (i % 3 == 2), 2, 8'(i + 50), 8'(i + 150));

      // clamping: 0 acts as 1, 31 acts as 16 with pointer wrap
      for (int i = 0; i < 6; i++) step(0, 1, 0, 8'(i + 10), 8'(i + 20));
      for (int i = 0; i < 40; i++) step(0, 1, 31, 8'(i + 60), 8'(200 - i));

      // delay change 8 -> 3 mid-stream
      for (int i = 0; i < 20; i++) step(0, 1, 8, 8'(i * 3), 8'(i * 5));
      for (int i = 0; i < 10; i++) step(0, 1, 3, 8'(i + 120), 8'(i + 130));

      // reset pulse mid-stream, then refill
      step(1, 1, 5, 8'hEE, 8'hDD);
      for (int i = 0; i < 10; i++) step(0, 1, 5, 8'(i + 1), 8'(i + 70));

      // randomized traffic
      cur_dc = 6;
      for (int i = 0; i < 500; i++) begin
         r = ($urandom_range(0, 99) < 2);
         e = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 15) == 0) cur_dc = $urandom_range(0, 31);
         step(r, e, cur_dc, 8'($urandom), 8'($urandom));
      end

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
      #2;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
